// File: rtl/mem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_responder_pkg
// Purpose : Shared types and constants for the memory responder: FSM state
//           encoding, data width and wait-state counter width.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_array.sv
//------------------------------------------------------------------------------
// Module  : mem_responder_array
// Purpose : Word storage for the memory responder. Synchronous write,
//           asynchronous read, 2**AW_WORDS words of DATA_W bits. Contents are
//           never reset.
// Ports   : clk      - clock
//           we_i     - write enable
//           waddr_i  - write word index
//           wdata_i  - write data
//           raddr_i  - read word index
//           rdata_o  - read data (combinational)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int AW_WORDS = 9
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW_WORDS-1:0] waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [AW_WORDS-1:0] raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// Module  : mem_responder
// Purpose : Single-outstanding memory target. Accepts one request in IDLE,
//           waits WAIT_CYCLES wait states, then presents a response held until
//           resp_ready. One idle cycle with req_ready low follows every
//           completed response before the next request can be accepted.
// Macro   : MEM_RESPONDER_ERR_CHECK_EN - when defined, misaligned or
//           out-of-range addresses are rejected with resp_err; otherwise the
//           address is truncated to the word index (aliasing modulo depth).
// Ports   : clk, reset (async, active high)
//           req_valid/req_ready/req_we/req_addr/req_wdata - request channel
//           resp_valid/resp_ready/resp_rdata/resp_err    - response channel
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW_WORDS    = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gap_q, gap_d;
  logic                we_q;
  logic [AW_WORDS-1:0] idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                resp_err_q;

  logic                w_accept;
  logic                w_enter_resp;
  logic                w_req_err;
  logic [AW_WORDS-1:0] w_req_idx;
  logic [31:0]         w_addr_hi;
  logic                w_cur_we;
  logic                w_cur_err;
  logic [AW_WORDS-1:0] w_cur_idx;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic                w_mem_we;

  assign w_req_idx = req_addr[AW_WORDS+1:2];
  // Everything above the word index; nonzero means outside the storage.
  assign w_addr_hi = req_addr >> (AW_WORDS + 2);

`ifdef MEM_RESPONDER_ERR_CHECK_EN
  assign w_req_err = (req_addr[1:0] != 2'b00) || (w_addr_hi != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = |{w_addr_hi, req_addr[1:0]};
  assign w_req_err        = 1'b0;
`endif

  // With zero wait states RESP is entered on the accepting edge itself, so
  // the access must use the live request rather than the latched copy.
  assign w_cur_we    = w_accept ? req_we    : we_q;
  assign w_cur_err   = w_accept ? w_req_err : err_q;
  assign w_cur_idx   = w_accept ? w_req_idx : idx_q;
  assign w_cur_wdata = w_accept ? req_wdata : wdata_q;

  assign req_ready  = (state_q == ST_IDLE) && !gap_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    gap_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          gap_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated with reset so a zero-wait accept cannot write during reset.
  assign w_mem_we = w_enter_resp && w_cur_we && !w_cur_err && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      if (w_accept) begin
        we_q    <= req_we;
        idx_q   <= w_req_idx;
        wdata_q <= req_wdata;
        err_q   <= w_req_err;
      end
      if (w_enter_resp) begin
        rdata_q    <= (w_cur_we || w_cur_err) ? '0 : w_mem_rdata;
        resp_err_q <= w_cur_err;
      end
    end
  end

  mem_responder_array #(
    .AW_WORDS (AW_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (w_mem_we),
    .waddr_i (w_cur_idx),
    .wdata_i (w_cur_wdata),
    .raddr_i (w_cur_idx),
    .rdata_o (w_mem_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_responder
// Purpose : Directed self-checking bench for mem_responder. u_dut uses default
//           parameters; u_dut0 uses WAIT_CYCLES=0 for the back-to-back case.
//           Expected values follow MEM_RESPONDER_ERR_CHECK_EN when defined.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_we0, resp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_responder u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid0),
    .req_ready  (req_ready0),
    .req_we     (req_we0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .resp_valid (resp_valid0),
    .resp_ready (resp_ready0),
    .resp_rdata (resp_rdata0),
    .resp_err   (resp_err0)
  );

  // One complete transaction on u_dut, entered and left 1ns after a rising edge.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1; resp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    vectors++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_req_ready0 got %b want 1", req_ready0); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    vectors++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    vectors++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata got %h want 0", rd); end
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    vectors++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", er); end
    vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_addr_errors();
    logic [31:0] rd; logic er; int lat;
    logic exp_err;
    logic [31:0] exp_rd_13, exp_rd_0;
`ifdef MEM_RESPONDER_ERR_CHECK_EN
    exp_err = 1'b1; exp_rd_13 = 32'd0;         exp_rd_0 = 32'h11111111;
`else
    exp_err = 1'b0; exp_rd_13 = 32'hDEADBEEF;  exp_rd_0 = 32'hCAFEF00D;
`endif
    run_txn(1'b0, 32'h13, 32'h0, rd, er, lat);
    vectors++; if (er !== exp_err) begin errors++; $display("FAIL misalign_err got %b want %b", er, exp_err); end
    vectors++; if (rd !== exp_rd_13) begin errors++; $display("FAIL misalign_rdata got %h want %h", rd, exp_rd_13); end
    vectors++; if (lat !== 3) begin errors++; $display("FAIL misalign_latency got %0d want 3", lat); end
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL after_err_rdata got %h want deadbeef", rd); end
    run_txn(1'b1, 32'h0, 32'h11111111, rd, er, lat);
    run_txn(1'b1, 32'h800, 32'hCAFEF00D, rd, er, lat);
    vectors++; if (er !== exp_err) begin errors++; $display("FAIL range_err got %b want %b", er, exp_err); end
    vectors++; if (lat !== 3) begin errors++; $display("FAIL range_latency got %0d want 3", lat); end
    run_txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    vectors++; if (rd !== exp_rd_0) begin errors++; $display("FAIL word0_rdata got %h want %h", rd, exp_rd_0); end
    vectors++; if (er !== 1'b0) begin errors++; $display("FAIL word0_err got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    int guard;
    req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1; resp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", i, resp_valid); end
      vectors++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rdata[%0d] got %h want deadbeef", i, resp_rdata); end
      vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready[%0d] got %b want 0", i, req_ready); end
      @(posedge clk); #1;
    end
    vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_end_valid got %b want 1", resp_valid); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", resp_valid); end
    vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL gap_req_ready got %b want 0", req_ready); end
    @(posedge clk); #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int guard;
    run_txn(1'b1, 32'h20, 32'hAAAA5555, rd, er, lat);
    run_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1; resp_ready = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL abort_rdata got %h want 0", resp_rdata); end
    vectors++; if (resp_err !== 1'b0) begin errors++; $display("FAIL abort_err got %b want 0", resp_err); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    run_txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++; if (rd !== 32'hAAAA5555) begin errors++; $display("FAIL abort_keep_rdata got %h want aaaa5555", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy, exp_rv;
    req_we0 = 1'b1; req_addr0 = 32'h40; req_wdata0 = 32'h0BADF00D; resp_ready0 = 1'b1; req_valid0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_rdy = ((i % 3) == 0);
      exp_rv  = ((i % 3) == 1);
      vectors++; if (req_ready0 !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, req_ready0, exp_rdy); end
      vectors++; if (resp_valid0 !== exp_rv) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i, resp_valid0, exp_rv); end
      @(posedge clk); #1;
    end
    req_valid0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; resp_ready0 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_addr_errors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
